// File: rtl/seg_scan_driver_pkg.sv
// Purpose: shared constants, state encoding and helpers for the seg_scan_driver slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_scan_driver_pkg;

  // Internal segment polarity is always 1 = lit, so "all off" is zero.
  localparam logic [6:0] SEG_OFF = 7'b0;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // One-hot digit enable for digit idx out of n digits (n <= 8).
  // The result is 8 bits wide; callers truncate to their digit count.
  function automatic logic [7:0] onehot(input logic [2:0] idx, input int n);
    onehot = 8'b0;
    if (int'(idx) < n) onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/seg_scan_driver_scan_timer.sv
// Purpose: per-digit slot timer; counts 0..SCAN_DIV-1 and flags slot end / blank window.
// Latency: o_slot_end is combinational on the current tick; o_in_blank_nxt describes the next tick.
// Backpressure: none, free-running.
// Ports: i_clk, i_rst (sync, active-high), o_slot_end (tick == SCAN_DIV-1),
//        o_in_blank_nxt (tick value after this edge falls inside the blanking window).
module seg_scan_driver_scan_timer #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_slot_end,
  output logic o_in_blank_nxt
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] LAST_TICK = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] BLANK_LIM = TW'(BLANK_CYCLES);

  logic [TW-1:0] r_tick;
  logic [TW-1:0] w_tick_nxt;

  always_comb begin
    o_slot_end     = (r_tick == LAST_TICK);
    w_tick_nxt     = o_slot_end ? '0 : r_tick + TW'(1);
    // The top registers its outputs from next-cycle values, so it needs the
    // blank decision for the tick that is about to be loaded.
    o_in_blank_nxt = (w_tick_nxt < BLANK_LIM);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_tick <= '0;
    else       r_tick <= w_tick_nxt;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Purpose: time-multiplexes NUM_DIGITS double-buffered 7-seg patterns onto one segment bus.
// Latency: outputs registered, aligned with the slot counters; new data appears from the next digit-0 slot.
// Backpressure: none; load always accepted, last load before a frame wrap wins.
// Ports: clk, rst (sync, active-high), digits_in (7 bits/digit, bit0=a), blank_mask (1 = digit dark),
//        load (capture strobe), seg/an (polarity per ACTIVE_LOW), frame_done (pulse when scan returns to digit 0).
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic w_slot_end;
  logic w_in_blank_nxt;

  seg_scan_driver_scan_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_slot_end     (w_slot_end),
    .o_in_blank_nxt (w_in_blank_nxt)
  );

  logic [IW-1:0]           r_idx;
  logic [7*NUM_DIGITS-1:0] r_disp_dat, r_pend_dat;
  logic [NUM_DIGITS-1:0]   r_disp_mask, r_pend_mask;
  logic                    r_disp_vld, r_pend_vld;
  logic                    r_frame_done;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_wrap;
  logic [IW-1:0]           w_idx_nxt;
  logic [7*NUM_DIGITS-1:0] w_disp_dat, w_pend_dat;
  logic [NUM_DIGITS-1:0]   w_disp_mask, w_pend_mask;
  logic                    w_disp_vld, w_pend_vld;
  state_t                  w_state_nxt;
  logic                    w_show;
  logic [6:0]              w_seg_int;
  logic [NUM_DIGITS-1:0]   w_an_int;

  always_comb begin
    w_wrap    = w_slot_end && (r_idx == LAST_IDX);
    w_idx_nxt = r_idx;
    if (w_slot_end) w_idx_nxt = w_wrap ? '0 : r_idx + IW'(1);

    w_disp_dat  = r_disp_dat;
    w_disp_mask = r_disp_mask;
    w_disp_vld  = r_disp_vld;
    w_pend_dat  = r_pend_dat;
    w_pend_mask = r_pend_mask;
    w_pend_vld  = r_pend_vld;
    if (w_wrap && load) begin
      // A load landing on the wrap edge bypasses pending so digit 0 of the
      // new frame already shows it; any older pending data is superseded.
      w_disp_dat  = digits_in;
      w_disp_mask = blank_mask;
      w_disp_vld  = 1'b1;
      w_pend_vld  = 1'b0;
    end else begin
      if (w_wrap && r_pend_vld) begin
        w_disp_dat  = r_pend_dat;
        w_disp_mask = r_pend_mask;
        w_disp_vld  = 1'b1;
        w_pend_vld  = 1'b0;
      end
      if (load) begin
        w_pend_dat  = digits_in;
        w_pend_mask = blank_mask;
        w_pend_vld  = 1'b1;
      end
    end

    // Outputs are registered from next-cycle values so they line up with the
    // tick/idx registers rather than trailing them by a cycle. Nothing lights
    // until real data has reached the display buffer after reset.
    w_state_nxt = w_in_blank_nxt ? ST_BLANK : ST_SHOW;
    w_show      = (w_state_nxt == ST_SHOW) && w_disp_vld && !w_disp_mask[w_idx_nxt];
    w_seg_int   = w_show ? w_disp_dat[7*int'(w_idx_nxt) +: 7] : SEG_OFF;
    w_an_int    = w_show ? NUM_DIGITS'(onehot(3'(w_idx_nxt), NUM_DIGITS)) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_disp_dat   <= '0;
      r_disp_mask  <= '0;
      r_disp_vld   <= 1'b0;
      r_pend_dat   <= '0;
      r_pend_mask  <= '0;
      r_pend_vld   <= 1'b0;
      r_frame_done <= 1'b0;
      r_seg        <= SEG_OFF ^ {7{POL}};
      r_an         <= {NUM_DIGITS{POL}};
    end else begin
      r_idx        <= w_idx_nxt;
      r_disp_dat   <= w_disp_dat;
      r_disp_mask  <= w_disp_mask;
      r_disp_vld   <= w_disp_vld;
      r_pend_dat   <= w_pend_dat;
      r_pend_mask  <= w_pend_mask;
      r_pend_vld   <= w_pend_vld;
      r_frame_done <= w_wrap;
      r_seg        <= w_seg_int ^ {7{POL}};
      r_an         <= w_an_int ^ {NUM_DIGITS{POL}};
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] digits_in;
  logic [3:0]  blank_mask;
  logic        load;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [6:0] pat_a [4] = '{7'h3F, 7'h4F, 7'h5B, 7'h06};
  logic [6:0] pat_b [4] = '{7'h7F, 7'h4F, 7'h5B, 7'h06};

  seg_scan_driver #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .blank_mask (blank_mask),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick_clk();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; digits_in = '0; blank_mask = '0;
    repeat (3) begin
      tick_clk();
      total++;
      if ({an, seg, frame_done} !== {4'b1111, 7'h7F, 1'b0}) begin
        bad++;
        $display("FAIL reset_hold an=%b seg=%h fd=%b want an=1111 seg=7f fd=0", an, seg, frame_done);
      end
    end
    rst = 1'b0;
    cyc = 0;
    repeat (7) begin
      tick_clk();
      total++;
      if ({an, seg, frame_done} !== {4'b1111, 7'h7F, 1'b0}) begin
        bad++;
        $display("FAIL reset_release cyc=%0d an=%b seg=%h fd=%b want an=1111 seg=7f fd=0", cyc, an, seg, frame_done);
      end
    end
  endtask

  task automatic test_load_frame();
    logic [3:0] ea;
    logic [6:0] es;
    while (cyc < 13) tick_clk();
    digits_in = {7'h06, 7'h5B, 7'h4F, 7'h3F};
    blank_mask = 4'b0000;
    load = 1'b1;
    tick_clk();
    load = 1'b0;
    while (cyc < 39) begin
      tick_clk();
      ea = 4'b1111; es = 7'h7F;
      if (cyc >= 34) begin ea = 4'b1110; es = 7'h40; end
      total++;
      if ({an, seg, frame_done} !== {ea, es, (cyc == 32)}) begin
        bad++;
        $display("FAIL load_frame cyc=%0d an=%b seg=%h fd=%b want an=%b seg=%h fd=%b",
                 cyc, an, seg, frame_done, ea, es, (cyc == 32));
      end
    end
  endtask

  task automatic test_blank_mask();
    logic [3:0] ea, m;
    logic [6:0] es;
    int t, d;
    blank_mask = 4'b1000;
    load = 1'b1;
    tick_clk();
    load = 1'b0;
    while (cyc < 95) begin
      tick_clk();
      t = cyc % 8; d = (cyc / 8) % 4;
      m = (cyc >= 64) ? 4'b1000 : 4'b0000;
      ea = 4'b1111; es = 7'h7F;
      if (t >= 2 && !m[d]) begin
        ea = 4'b1111 ^ (4'b0001 << d);
        es = ~pat_a[d];
      end
      total++;
      if ({an, seg, frame_done} !== {ea, es, (cyc == 64)}) begin
        bad++;
        $display("FAIL blank_mask cyc=%0d an=%b seg=%h fd=%b want an=%b seg=%h", cyc, an, seg, frame_done, ea, es);
      end
    end
  endtask

  task automatic test_wrap_load();
    logic [3:0] ea;
    logic [6:0] es;
    int t, d;
    digits_in = {7'h06, 7'h5B, 7'h4F, 7'h7F};
    blank_mask = 4'b0000;
    load = 1'b1;
    tick_clk();
    load = 1'b0;
    total++;
    if ({an, seg, frame_done} !== {4'b1111, 7'h7F, 1'b1}) begin
      bad++;
      $display("FAIL wrap_load_edge an=%b seg=%h fd=%b want an=1111 seg=7f fd=1", an, seg, frame_done);
    end
    // A stale pending flag would swap in the masked data at cycle 128.
    while (cyc < 135) begin
      tick_clk();
      t = cyc % 8; d = (cyc / 8) % 4;
      ea = 4'b1111; es = 7'h7F;
      if (t >= 2) begin
        ea = 4'b1111 ^ (4'b0001 << d);
        es = ~pat_b[d];
      end
      total++;
      if ({an, seg, frame_done} !== {ea, es, (cyc == 128)}) begin
        bad++;
        $display("FAIL wrap_load cyc=%0d an=%b seg=%h fd=%b want an=%b seg=%h", cyc, an, seg, frame_done, ea, es);
      end
    end
  endtask

  task automatic test_mid_reset();
    digits_in = {4{7'h7F}};
    blank_mask = 4'b0000;
    load = 1'b1;
    tick_clk();
    load = 1'b0;
    while (cyc < 146) tick_clk();
    total++;
    if ({an, seg} !== {4'b1011, 7'h24}) begin
      bad++;
      $display("FAIL mid_reset_pre an=%b seg=%h want an=1011 seg=24", an, seg);
    end
    rst = 1'b1;
    tick_clk();
    total++;
    if ({an, seg, frame_done} !== {4'b1111, 7'h7F, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset_hit an=%b seg=%h fd=%b want an=1111 seg=7f fd=0", an, seg, frame_done);
    end
    rst = 1'b0;
    cyc = 0;
    repeat (40) begin
      tick_clk();
      total++;
      if ({an, seg, frame_done} !== {4'b1111, 7'h7F, (cyc == 32)}) begin
        bad++;
        $display("FAIL mid_reset_after cyc=%0d an=%b seg=%h fd=%b want an=1111 seg=7f fd=%b",
                 cyc, an, seg, frame_done, (cyc == 32));
      end
    end
  endtask

  task automatic test_steady_scan();
    int last_fd = -1;
    int pulses  = 0;
    logic prev_fd = 1'b0;
    digits_in = {7'h06, 7'h5B, 7'h4F, 7'h3F};
    blank_mask = 4'b0000;
    load = 1'b1;
    tick_clk();
    load = 1'b0;
    repeat (100) begin
      tick_clk();
      total++;
      if ($countones(~an) > 1) begin
        bad++;
        $display("FAIL steady_onehot cyc=%0d an=%b want at most one low bit", cyc, an);
      end
      total++;
      if (frame_done !== (cyc % 32 == 0)) begin
        bad++;
        $display("FAIL steady_fd cyc=%0d fd=%b want %b", cyc, frame_done, (cyc % 32 == 0));
      end
      if (frame_done === 1'b1) begin
        total++;
        if (prev_fd) begin
          bad++;
          $display("FAIL steady_fd_width cyc=%0d fd high two cycles running, want 1-cycle pulse", cyc);
        end
        if (last_fd >= 0) begin
          total++;
          if (cyc - last_fd != 32) begin
            bad++;
            $display("FAIL steady_fd_period got=%0d want=32", cyc - last_fd);
          end
        end
        last_fd = cyc;
        pulses++;
      end
      prev_fd = frame_done;
    end
    total++;
    if (pulses != 3) begin
      bad++;
      $display("FAIL steady_pulse_count got=%0d want=3", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_load_frame();
    test_blank_mask();
    test_wrap_load();
    test_mid_reset();
    test_steady_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
